line_mem_model: RTL and testbench
=================================

# line_mem_model

Parametrised, cycle-accurate main-memory model that sits behind `cache_controller` on its main-memory port. It services line-fill reads and word write-throughs with configurable read and write latency, and returns a full cache line per read. It flags out-of-range accesses instead of aliasing them. It replaces the ad-hoc single-word memory model used in cache-level benches and is reused by the MMU benches.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `WORD_W`, 32, word width in bits; power of two, ≥8.
- `WORDS_PER_LINE`, 16, words per cache line; power of two.
- `DEPTH_WORDS`, 4096, storage depth in words; multiple of `WORDS_PER_LINE`.
- `RD_LATENCY`, 4, read wait cycles; ≥1.
- `WR_LATENCY`, 2, write wait cycles; ≥1.

Ports:
- `clk`, in, 1, sole clock; all logic on the rising edge.
- `rst_n`, in, 1, reset; synchronous, active-low.
- `mem_addr`, in, `ADDR_W`, byte address of the request.
- `mem_read_req`, in, 1, line-read request level.
- `mem_write_req`, in, 1, word-write request level.
- `mem_wdata`, in, `WORD_W`, write data.
- `mem_rdata`, out, `WORD_W*WORDS_PER_LINE`, read line; word k at bits [k*WORD_W +: WORD_W].
- `mem_ready`, out, 1, one-cycle completion pulse.
- `mem_err`, out, 1, out-of-range flag; valid with `mem_ready`.
- `mem_busy`, out, 1, high whenever state ≠ IDLE.

## Operation
- Word index: `mem_addr >> log2(WORD_W/8)`. Byte-offset bits are ignored.
- Line base: word index with its low `log2(WORDS_PER_LINE)` bits cleared.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, DONE.
- IDLE:
  - `mem_read_req` high → latch address → READ_WAIT, latency counter cleared.
  - Else `mem_write_req` high → latch address and `mem_wdata` → WRITE_WAIT.
  - Read has priority when both are high; the write is dropped, not queued.
- Request inputs are ignored outside IDLE. Changes to `mem_addr` or `mem_wdata` after acceptance have no effect.
- READ_WAIT:
  - Counter increments each cycle.
  - At count `RD_LATENCY-1`, load `mem_rdata` with words base..base+`WORDS_PER_LINE`-1 → DONE.
- WRITE_WAIT:
  - At count `WR_LATENCY-1`, commit the latched word to the latched index → DONE.
- DONE: `mem_ready`←1 for one cycle → IDLE.
- Out of range (word index ≥ `DEPTH_WORDS`):
  - Full latency is still spent.
  - `mem_err`←1 together with `mem_ready`.
  - Read returns all ones in every word.
  - Write leaves storage unchanged.
- `mem_rdata` holds its value until the next read completes; writes do not alter it.
- Storage is initialised to all ones at time zero and is not cleared by reset.
- Requester must deassert its request in the cycle `mem_ready` is high. A request still high one cycle later is taken as a new transaction.

## Timing
- Reset values: state IDLE, `mem_ready`=0, `mem_err`=0, `mem_busy`=0, `mem_rdata`=0, counter 0.
- `mem_busy` rises in the cycle after acceptance.
- Request accepted at edge N:
  - Read data registered at edge N+`RD_LATENCY`.
  - `mem_ready` high from edge N+`RD_LATENCY`+1 for exactly one cycle.
  - Write commits at edge N+`WR_LATENCY`; `mem_ready` high from edge N+`WR_LATENCY`+1.
  - `mem_busy` falls at the same edge `mem_ready` rises.
- Earliest next acceptance is one edge after `mem_ready` rises.
- Throughput: one transaction per `LATENCY`+2 cycles.
- Reset mid-transaction: return to IDLE on the reset edge with outputs at reset values.
  - A write not yet committed is discarded.
  - A write already committed stays committed.
  - No `mem_ready` pulse for the aborted transaction.
- `rst_n` low overrides any request present in the same cycle.

## Configuration
- `LINE_MEM_TRACE_EN` defined: every accept and completion prints a simulation line with op, byte address, word index, data (write) or word 0 (read), err flag and completion time.
- Undefined: no display statements are compiled. Cycle behaviour is identical in both builds.

## Test plan
Defaults throughout; word index = addr>>2.
- Reset: `rst_n` low 2 cycles with `mem_read_req` high → `mem_ready`/`mem_err`/`mem_busy` 0 and `mem_rdata`=0 throughout; first accept at the edge after `rst_n` rises.
- Write then read:
  - Write 0x44 data 0xDEADBEEF → `mem_ready` 3 edges after accept, `mem_err`=0.
  - Then read 0x40 → `mem_ready` 5 edges after accept; word1=0xDEADBEEF, the other 15 words 0xFFFFFFFF.
- Simultaneous read+write at 0x80 with data 0x11111111 → read serviced; a following read of 0x80 shows word0=0xFFFFFFFF.
- Out of range:
  - Read 0x4000 → `mem_ready`+`mem_err` after 5 edges, all-ones line.
  - Write 0x4000 → `mem_err`; a read of 0x0 returns all ones.
- Reset mid-write: accept write 0x100 data 0x12345678, drop `rst_n` on the next edge → no `mem_ready`; a later read of 0x100 gives word0=0xFFFFFFFF.
- Held request: `mem_read_req` kept high → `mem_ready` pulses every 6 cycles, each pulse exactly one cycle wide.

Source files
------------

// File: rtl/line_mem_model.sv
// Cycle-accurate main-memory model: full-line reads, word write-through, fixed latencies.
// Define LINE_MEM_TRACE_EN to print a line per accepted and completed transaction.
module line_mem_model #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 16,
  parameter int DEPTH_WORDS    = 4096,
  parameter int RD_LATENCY     = 4,
  parameter int WR_LATENCY     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_read_req,
  input  logic                             mem_write_req,
  input  logic [WORD_W-1:0]                mem_wdata,
  output logic [WORD_W*WORDS_PER_LINE-1:0] mem_rdata,
  output logic                             mem_ready,
  output logic                             mem_err,
  output logic                             mem_busy
);
  localparam int OFF_W   = $clog2(WORD_W/8);
  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT+1);
  localparam int LINE_W  = WORD_W*WORDS_PER_LINE;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              err_q;

  // Storage powers up all ones and survives reset.
  logic [WORD_W-1:0] mem [DEPTH_WORDS] = '{default: '1};

  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic [IDX_W-1:0]  line_base;
  logic [LINE_W-1:0] line_data;
  logic              wr_commit;

  assign idx       = mem_addr >> OFF_W;
  assign in_range  = idx < ADDR_W'(DEPTH_WORDS);
  assign line_base = idx_q & ~IDX_W'(WORDS_PER_LINE-1);

  always_comb begin
    line_data = '0;
    for (int k = 0; k < WORDS_PER_LINE; k++)
      line_data[k*WORD_W +: WORD_W] = mem[line_base | IDX_W'(k)];
  end

  assign wr_commit = rst_n && (state == WRITE_WAIT) &&
                     (cnt == CNT_W'(WR_LATENCY-1)) && !err_q;

  always_ff @(posedge clk)
    if (wr_commit) mem[idx_q] <= wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_busy  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read_req) begin
            state    <= READ_WAIT;
            idx_q    <= idx[IDX_W-1:0];
            err_q    <= !in_range;
            cnt      <= '0;
            mem_busy <= 1'b1;
          end else if (mem_write_req) begin
            state    <= WRITE_WAIT;
            idx_q    <= idx[IDX_W-1:0];
            wdata_q  <= mem_wdata;
            err_q    <= !in_range;
            cnt      <= '0;
            mem_busy <= 1'b1;
          end
        end
        READ_WAIT: begin
          if (cnt == CNT_W'(RD_LATENCY-1)) begin
            mem_rdata <= err_q ? '1 : line_data;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE_WAIT: begin
          if (cnt == CNT_W'(WR_LATENCY-1)) state <= DONE;
          else                             cnt   <= cnt + 1'b1;
        end
        DONE: begin
          mem_ready <= 1'b1;
          mem_err   <= err_q;
          mem_busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_MEM_TRACE_EN
  logic [ADDR_W-1:0] trace_addr;
  logic              trace_rd;
  always @(posedge clk) begin
    if (rst_n && state == IDLE && (mem_read_req || mem_write_req)) begin
      trace_addr <= mem_addr;
      trace_rd   <= mem_read_req;
      $display("[line_mem] accept %s addr=%h idx=%0d data=%h t=%0t",
               mem_read_req ? "RD" : "WR", mem_addr, idx,
               mem_read_req ? {WORD_W{1'b0}} : mem_wdata, $time);
    end
    if (rst_n && state == DONE)
      $display("[line_mem] done   %s addr=%h idx=%0d data=%h err=%0b t=%0t",
               trace_rd ? "RD" : "WR", trace_addr, idx_q,
               trace_rd ? mem_rdata[WORD_W-1:0] : wdata_q, err_q, $time);
  end
`endif

endmodule

// File: tb/tb_line_mem_model.sv
// Directed bench for line_mem_model: vector table of transactions plus reset and held-request sequences.
module tb_line_mem_model;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  mem_addr;
  logic         mem_read_req;
  logic         mem_write_req;
  logic [31:0]  mem_wdata;
  logic [511:0] mem_rdata;
  logic         mem_ready;
  logic         mem_err;
  logic         mem_busy;

  line_mem_model dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_addr     (mem_addr),
    .mem_read_req (mem_read_req),
    .mem_write_req(mem_write_req),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .mem_err      (mem_err),
    .mem_busy     (mem_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    int          k;      // expected line: all ones except word k = v
    logic [31:0] v;
  } vec_t;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [511:0] last_line;
  localparam logic [511:0] ONES = {512{1'b1}};

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int id);
    logic [511:0] exp;
    int           n;
    logic         got;
    exp = ONES;
    exp[v.k*32 +: 32] = v.v;
    @(negedge clk);
    mem_read_req  = v.rd;
    mem_write_req = v.wr;
    mem_addr      = v.addr;
    mem_wdata     = v.wdata;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the latched copy must be used.
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    mem_addr      = 32'hFFFF_FFF0;
    mem_wdata     = 32'h5555_5555;
    chk($sformatf("v%0d busy_after_accept", id), 512'(mem_busy), 512'(1'b1));
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk); #1;
      n++;
      got = mem_ready;
    end
    chk($sformatf("v%0d latency", id), 512'(n), 512'(v.lat));
    chk($sformatf("v%0d err", id), 512'(mem_err), 512'(v.err));
    chk($sformatf("v%0d busy_at_ready", id), 512'(mem_busy), 512'(1'b0));
    if (v.rd) last_line = exp;
    chk($sformatf("v%0d rdata", id), mem_rdata, last_line);
    @(posedge clk); #1;
    chk($sformatf("v%0d ready_width", id), 512'(mem_ready), 512'(1'b0));
  endtask

  initial begin
    vec_t vt [13];
    int   n;
    logic got;
    int   pulses;
    int   pedge [8];
    logic prev;

    vt[0]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 3, 1'b0, 0,  32'hFFFF_FFFF};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         5, 1'b0, 1,  32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 1'b1, 32'h0000_0080, 32'h1111_1111, 5, 1'b0, 0,  32'hFFFF_FFFF};
    vt[3]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         5, 1'b0, 0,  32'hFFFF_FFFF};
    vt[4]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         5, 1'b1, 0,  32'hFFFF_FFFF};
    vt[5]  = '{1'b0, 1'b1, 32'h0000_4000, 32'h0000_0000, 3, 1'b1, 0,  32'hFFFF_FFFF};
    vt[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         5, 1'b0, 0,  32'hFFFF_FFFF};
    vt[7]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 3, 1'b0, 0,  32'hFFFF_FFFF};
    vt[8]  = '{1'b0, 1'b1, 32'h0000_000B, 32'h0F0F_0F0F, 3, 1'b0, 0,  32'hFFFF_FFFF};
    vt[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         5, 1'b0, 2,  32'h0F0F_0F0F};
    vt[10] = '{1'b0, 1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 3, 1'b0, 0,  32'hFFFF_FFFF};
    vt[11] = '{1'b1, 1'b0, 32'h0000_3FC0, 32'h0,         5, 1'b0, 15, 32'hCAFE_F00D};
    vt[12] = '{1'b1, 1'b0, 32'h0000_3FFF, 32'h0,         5, 1'b0, 15, 32'hCAFE_F00D};

    // Reset held with a pending read: nothing may start.
    rst_n = 1'b0; mem_read_req = 1'b1; mem_write_req = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst%0d ready", i), 512'(mem_ready), 512'(1'b0));
      chk($sformatf("rst%0d err", i),   512'(mem_err),   512'(1'b0));
      chk($sformatf("rst%0d busy", i),  512'(mem_busy),  512'(1'b0));
      chk($sformatf("rst%0d rdata", i), mem_rdata,       512'(0));
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mem_read_req = 1'b0;
    chk("rst first_accept_busy", 512'(mem_busy), 512'(1'b1));
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin @(posedge clk); #1; n++; got = mem_ready; end
    chk("rst first_latency", 512'(n), 512'(5));
    chk("rst first_line_ones", mem_rdata, ONES);
    last_line = ONES;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run(vt[i], i);

    // Reset one edge after a write is accepted: write discarded, no ready.
    @(negedge clk);
    mem_write_req = 1'b1; mem_addr = 32'h100; mem_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_write_req = 1'b0;
    chk("midrst busy_after_accept", 512'(mem_busy), 512'(1'b1));
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy", 512'(mem_busy), 512'(1'b0));
    chk("midrst rdata", mem_rdata, 512'(0));
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    chk("midrst no_ready", 512'(pulses), 512'(0));
    last_line = '0;
    run('{1'b1, 1'b0, 32'h0000_0100, 32'h0, 5, 1'b0, 0, 32'hFFFF_FFFF}, 13);

    // Held read request: a one-cycle ready every 6 cycles.
    @(negedge clk);
    mem_read_req = 1'b1; mem_addr = 32'h0;
    pulses = 0; prev = 1'b0;
    for (int e = 1; e <= 26; e++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        if (prev) chk($sformatf("held wide_pulse_e%0d", e), 512'(1'b1), 512'(prev ^ mem_ready));
        if (pulses < 8) pedge[pulses] = e;
        pulses++;
      end
      prev = mem_ready;
    end
    @(negedge clk); mem_read_req = 1'b0;
    chk("held pulse_count", 512'(pulses), 512'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("held pulse%0d_edge", i), 512'(pedge[i]), 512'(6 + 6*i));
    for (int i = 0; i < 10; i++) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
